// File: rtl/mp_reg_file.sv
// Multi-port integer register file with a write-pending scoreboard.
// Reads are registered with optional same-edge write forwarding; claims set pending, writes clear it.
`timescale 1ns/1ps
module mp_reg_file #(
   parameter int XLEN          = 32,
   parameter int NREGS         = 32,
   parameter int NRD           = 4,
   parameter int NWR           = 2,
   parameter int BYPASS        = 1,
   parameter int HARDWIRE_ZERO = 1,
   localparam int AW           = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [NRD*AW-1:0]   rs_addr,
   input  logic [NRD-1:0]      rs_en,
   output logic [NRD*XLEN-1:0] rs_data,
   output logic [NRD-1:0]      rs_pending,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   claim_addr,
   input  logic [NWR-1:0]      claim_en,
   output logic                write_collision
);

   logic [XLEN-1:0]     r_regs [NREGS];
   logic [NREGS-1:0]    r_pending;
   logic [NRD*XLEN-1:0] r_rs_data;
   logic [NRD-1:0]      r_rs_pending;
   logic                r_collision;

   logic [XLEN-1:0]     w_regs_next [NREGS];
   logic [NREGS-1:0]    w_cleared;
   logic [NREGS-1:0]    w_claimed;
   logic [NREGS-1:0]    w_pend_next;
   logic [NWR-1:0]      w_wr_ok;
   logic [NWR-1:0]      w_cl_ok;
   logic                w_collision;
   logic [NRD*XLEN-1:0] w_rd_data;
   logic [NRD-1:0]      w_rd_pend;

   // An address is usable when it is in range and not the hardwired zero register
   function automatic logic f_addr_ok(input logic [AW-1:0] a);
      logic ok;
      ok = ({{(32-AW){1'b0}}, a} < 32'(NREGS));
      if ((HARDWIRE_ZERO != 0) && (a == {AW{1'b0}})) begin
         ok = 1'b0;
      end else begin
         ok = ok;
      end
      return ok;
   endfunction

   // Post-edge register contents and scoreboard update; later write ports override earlier ones
   always_comb begin
      w_regs_next = r_regs;
      w_cleared   = {NREGS{1'b0}};
      w_claimed   = {NREGS{1'b0}};
      w_wr_ok     = {NWR{1'b0}};
      w_cl_ok     = {NWR{1'b0}};
      for (int k = 0; k < NWR; k++) begin
         w_wr_ok[k] = wr_en[k] & f_addr_ok(wr_addr[k*AW +: AW]);
         w_cl_ok[k] = claim_en[k] & f_addr_ok(claim_addr[k*AW +: AW]);
         for (int r = 0; r < NREGS; r++) begin
            if (w_wr_ok[k] && (wr_addr[k*AW +: AW] == AW'(r))) begin
               w_regs_next[r] = wr_data[k*XLEN +: XLEN];
               w_cleared[r]   = 1'b1;
            end else begin
               w_regs_next[r] = w_regs_next[r];
            end
            if (w_cl_ok[k] && (claim_addr[k*AW +: AW] == AW'(r))) begin
               w_claimed[r] = 1'b1;
            end else begin
               w_claimed[r] = w_claimed[r];
            end
         end
      end
      w_pend_next = (r_pending & ~w_cleared) | w_claimed;
   end

   // Two or more accepted writes aimed at the same register
   always_comb begin
      w_collision = 1'b0;
      for (int k = 0; k < NWR; k++) begin
         for (int m = k + 1; m < NWR; m++) begin
            if (w_wr_ok[k] && w_wr_ok[m] &&
                (wr_addr[k*AW +: AW] == wr_addr[m*AW +: AW])) begin
               w_collision = 1'b1;
            end else begin
               w_collision = w_collision;
            end
         end
      end
   end

   // Read mux; out-of-range addresses match no register and so return zero and not-pending
   always_comb begin
      w_rd_data = {(NRD*XLEN){1'b0}};
      w_rd_pend = {NRD{1'b0}};
      for (int j = 0; j < NRD; j++) begin
         for (int r = 0; r < NREGS; r++) begin
            if (rs_addr[j*AW +: AW] == AW'(r)) begin
               w_rd_data[j*XLEN +: XLEN] = (BYPASS != 0) ? w_regs_next[r] : r_regs[r];
               w_rd_pend[j]              = w_pend_next[r];
            end else begin
               w_rd_data[j*XLEN +: XLEN] = w_rd_data[j*XLEN +: XLEN];
               w_rd_pend[j]              = w_rd_pend[j];
            end
         end
      end
   end

   // Architectural state: register array and pending scoreboard
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NREGS; r++) begin
            r_regs[r] <= {XLEN{1'b0}};
         end
         r_pending <= {NREGS{1'b0}};
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            r_regs[r] <= w_regs_next[r];
         end
         r_pending <= w_pend_next;
      end
   end

   // Registered read ports (hold when disabled) and collision flag
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rs_data    <= {(NRD*XLEN){1'b0}};
         r_rs_pending <= {NRD{1'b0}};
         r_collision  <= 1'b0;
      end else begin
         for (int j = 0; j < NRD; j++) begin
            if (rs_en[j]) begin
               r_rs_data[j*XLEN +: XLEN] <= w_rd_data[j*XLEN +: XLEN];
               r_rs_pending[j]           <= w_rd_pend[j];
            end else begin
               r_rs_data[j*XLEN +: XLEN] <= r_rs_data[j*XLEN +: XLEN];
               r_rs_pending[j]           <= r_rs_pending[j];
            end
         end
         r_collision <= w_collision;
      end
   end

   assign rs_data         = r_rs_data;
   assign rs_pending      = r_rs_pending;
   assign write_collision = r_collision;

endmodule

// File: tb/tb_mp_reg_file.sv
// Self-checking bench for mp_reg_file: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file and scoreboard.
`timescale 1ns/1ps
module tb_mp_reg_file;
   localparam int XLEN = 32;
   localparam int NREGS = 32;
   localparam int NRD = 4;
   localparam int NWR = 2;
   localparam int BYPASS = 1;
   localparam int AW = 5;

   logic                clock = 1'b0;
   logic                reset_n;
   logic [NRD*AW-1:0]   rs_addr;
   logic [NRD-1:0]      rs_en;
   logic [NRD*XLEN-1:0] rs_data;
   logic [NRD-1:0]      rs_pending;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   claim_addr;
   logic [NWR-1:0]      claim_en;
   logic                write_collision;

   mp_reg_file #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
                 .BYPASS(BYPASS), .HARDWIRE_ZERO(1)) dut (
      .clock(clock), .reset_n(reset_n),
      .rs_addr(rs_addr), .rs_en(rs_en), .rs_data(rs_data), .rs_pending(rs_pending),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .claim_addr(claim_addr), .claim_en(claim_en),
      .write_collision(write_collision));

   always #5 clock = ~clock;

   // stimulus in per-port form
   logic [AW-1:0]   ra [NRD];
   logic [NRD-1:0]  re;
   logic [AW-1:0]   wa [NWR];
   logic [XLEN-1:0] wd [NWR];
   logic [NWR-1:0]  we;
   logic [AW-1:0]   ca [NWR];
   logic [NWR-1:0]  ce;

   // reference model
   logic [XLEN-1:0]  m_regs [NREGS];
   logic [NREGS-1:0] m_pend;
   logic [XLEN-1:0]  e_data [NRD];
   logic [NRD-1:0]   e_pend;
   logic             e_col;

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drive();
      for (int j = 0; j < NRD; j++) rs_addr[j*AW +: AW] = ra[j];
      for (int k = 0; k < NWR; k++) begin
         wr_addr[k*AW +: AW]     = wa[k];
         wr_data[k*XLEN +: XLEN] = wd[k];
         claim_addr[k*AW +: AW]  = ca[k];
      end
      rs_en = re; wr_en = we; claim_en = ce;
   endtask

   task automatic idle();
      for (int j = 0; j < NRD; j++) ra[j] = 5'd0;
      for (int k = 0; k < NWR; k++) begin wa[k] = 5'd0; wd[k] = 32'd0; ca[k] = 5'd0; end
      re = 4'd0; we = 2'd0; ce = 2'd0;
      drive();
   endtask

   task automatic reset_model();
      for (int r = 0; r < NREGS; r++) m_regs[r] = 32'd0;
      m_pend = 32'd0;
      for (int j = 0; j < NRD; j++) e_data[j] = 32'd0;
      e_pend = 4'd0; e_col = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_data"}, 128'(rs_data), 128'd0);
      chk({tag, "_pend"}, 128'(rs_pending), 128'd0);
      chk({tag, "_col"}, 128'(write_collision), 128'd0);
   endtask

   // Apply current stimulus for one clock and compare every output with the model
   task automatic step();
      logic [XLEN-1:0]  nr [NREGS];
      logic [NREGS-1:0] written, claimed, np;
      logic             col;
      drive();
      nr = m_regs; written = 32'd0; claimed = 32'd0; col = 1'b0;
      for (int k = 0; k < NWR; k++) begin
         if (we[k] && wa[k] != 5'd0) begin
            if (written[wa[k]]) col = 1'b1;
            nr[wa[k]] = wd[k];
            written[wa[k]] = 1'b1;
         end
      end
      for (int k = 0; k < NWR; k++)
         if (ce[k] && ca[k] != 5'd0) claimed[ca[k]] = 1'b1;
      np = (m_pend & ~written) | claimed;
      for (int j = 0; j < NRD; j++) begin
         if (re[j]) begin
            if (ra[j] == 5'd0) e_data[j] = 32'd0;
            else e_data[j] = (BYPASS != 0) ? nr[ra[j]] : m_regs[ra[j]];
            e_pend[j] = np[ra[j]];
         end
      end
      e_col = col;
      @(posedge clock); #1;
      m_regs = nr; m_pend = np;
      for (int j = 0; j < NRD; j++) begin
         chk($sformatf("rd%0d_data", j), 128'(rs_data[j*XLEN +: XLEN]), 128'(e_data[j]));
         chk($sformatf("rd%0d_pend", j), 128'(rs_pending[j]), 128'(e_pend[j]));
      end
      chk("collision", 128'(write_collision), 128'(e_col));
      @(negedge clock);
   endtask

   initial begin
      reset_n = 1'b0;
      idle();
      reset_model();
      // outputs stay clear while reset is held, whatever the inputs do
      for (int c = 0; c < 4; c++) begin
         rs_addr = 20'($urandom); rs_en = 4'($urandom);
         wr_addr = 10'($urandom); wr_data = {$urandom, $urandom}; wr_en = 2'($urandom);
         claim_addr = 10'($urandom); claim_en = 2'($urandom);
         @(posedge clock); #1;
         check_all_zero("in_reset");
      end
      @(negedge clock);
      reset_n = 1'b1;
      idle();

      // every register reads zero and not pending after reset
      for (int b = 1; b < NREGS; b += NRD) begin
         idle();
         re = 4'hF;
         for (int j = 0; j < NRD; j++) ra[j] = 5'(b + j);
         step();
      end

      // basic write then read on port 3
      idle(); we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; step();
      idle(); re[3] = 1'b1; ra[3] = 5'd5; step();
      chk("basic_rw", 128'(rs_data[3*XLEN +: XLEN]), 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);

      // same-edge write forwards to the read
      idle(); we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h1234; re[0] = 1'b1; ra[0] = 5'd7; step();
      chk("bypass", 128'(rs_data[XLEN-1:0]), 128'h1234);

      // collision: port 1 wins, flag for one cycle only
      idle(); we = 2'b11; wa[0] = 5'd9; wd[0] = 32'hAAAA; wa[1] = 5'd9; wd[1] = 32'h5555; step();
      chk("collision_set", 128'(write_collision), 128'd1);
      idle(); re[0] = 1'b1; ra[0] = 5'd9; step();
      chk("collision_clear", 128'(write_collision), 128'd0);
      chk("collision_winner", 128'(rs_data[XLEN-1:0]), 128'h5555);

      // scoreboard: claim, write clears, claim+write keeps pending
      idle(); ce[0] = 1'b1; ca[0] = 5'd3; step();
      idle(); re[0] = 1'b1; ra[0] = 5'd3; step();
      chk("claim_pend", 128'(rs_pending[0]), 128'd1);
      idle(); we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h77; re[0] = 1'b1; ra[0] = 5'd3; step();
      chk("write_clears", 128'(rs_pending[0]), 128'd0);
      idle(); we[1] = 1'b1; wa[1] = 5'd3; wd[1] = 32'h88; ce[1] = 1'b1; ca[1] = 5'd3;
      re[0] = 1'b1; ra[0] = 5'd3; step();
      chk("claim_wins_pend", 128'(rs_pending[0]), 128'd1);
      chk("claim_wins_data", 128'(rs_data[XLEN-1:0]), 128'h88);

      // x0 ignores writes and claims
      idle(); we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFF; ce[0] = 1'b1; ca[0] = 5'd0;
      re[0] = 1'b1; ra[0] = 5'd0; step();
      idle(); re[1] = 1'b1; ra[1] = 5'd0; step();
      chk("x0_data", 128'(rs_data[2*XLEN-1:XLEN]), 128'd0);
      chk("x0_pend", 128'(rs_pending[1]), 128'd0);

      // randomized traffic over a narrow address window to provoke overlaps
      for (int c = 0; c < 400; c++) begin
         for (int j = 0; j < NRD; j++)
            ra[j] = (($urandom % 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         for (int k = 0; k < NWR; k++) begin
            wa[k] = (($urandom % 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ca[k] = (($urandom % 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wd[k] = $urandom;
         end
         re = 4'($urandom); we = 2'($urandom); ce = 2'($urandom);
         step();
      end

      // asynchronous reset in the middle of a burst
      for (int k = 0; k < NWR; k++) begin wa[k] = 5'(k + 10); wd[k] = $urandom; ca[k] = 5'(k + 12); end
      we = 2'b11; ce = 2'b11; re = 4'hF;
      drive();
      @(posedge clock); #3;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clock);
      reset_n = 1'b1;
      idle();
      reset_model();
      for (int b = 8; b < 16; b += NRD) begin
         idle();
         re = 4'hF;
         for (int j = 0; j < NRD; j++) ra[j] = 5'(b + j);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
